// File: rtl/dmi_jtag_ctrl_pkg.sv
// Shared DMI/DTM types for the TCK-domain DMI controller: DTM op codes,
// sticky error codes, request record and controller state encodings.
package dmi_jtag_ctrl_pkg;

  localparam int DmiDataWidth = 32;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    NoError  = 2'd0,
    Reserved = 2'd1,
    Failed   = 2'd2,
    Busy     = 2'd3
  } dmi_error_e;

  // Low part of a DR / FIFO entry; the address sits above it and is
  // sized by the instantiating module.
  typedef struct packed {
    logic [DmiDataWidth-1:0] data;
    dtm_op_e                 op;
  } dmi_req_body_t;

  localparam int DmiReqBodyWidth = DmiDataWidth + 2;

  // Controller FSM encodings
  localparam logic [1:0] CtrlIdle  = 2'd0;
  localparam logic [1:0] CtrlIssue = 2'd1;
  localparam logic [1:0] CtrlWait  = 2'd2;

  function automatic logic is_rw_op(input logic [1:0] op);
    return (op == DTM_READ) || (op == DTM_WRITE);
  endfunction

endpackage

// File: rtl/dmi_jtag_ctrl_if.sv
// Request/response bus between the DMI JTAG controller (master) and the
// DMI clock-domain crossing (slave).
interface dmi_jtag_ctrl_if #(
  parameter int AbitsWidth = 7
);
  import dmi_jtag_ctrl_pkg::*;

  logic [AbitsWidth-1:0]   req_addr;
  logic [DmiDataWidth-1:0] req_data;
  logic [1:0]              req_op;
  logic                    req_valid;
  logic                    req_ready;
  logic [DmiDataWidth-1:0] resp_data;
  logic [1:0]              resp_resp;
  logic                    resp_valid;
  logic                    resp_ready;

  modport master (
    output req_addr, req_data, req_op, req_valid, resp_ready,
    input  req_ready, resp_data, resp_resp, resp_valid
  );

  modport slave (
    input  req_addr, req_data, req_op, req_valid, resp_ready,
    output req_ready, resp_data, resp_resp, resp_valid
  );

endinterface

// File: rtl/dmi_jtag_ctrl_req_fifo.sv
// DMI request FIFO: array storage with a registered read port that loads
// the head entry on pop and holds it for the in-flight transaction.
// Each slot carries a mark bit (set for reads) so the owner can ask
// whether any marked entry is still queued without reading the array.
module dmi_jtag_ctrl_req_fifo #(
  parameter int Depth = 2,
  parameter int Width = 41
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [Width-1:0]           push_data,
  input  logic                       push_mark,
  input  logic                       pop,
  output logic [Width-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       any_mark
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] pop_data_reg;
  logic [PtrW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0]  count_reg, count_next;
  logic [Depth-1:0] slot_live;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Storage write port, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Registered read port: head entry captured on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_data_reg <= '0;
    end else if (pop) begin
      pop_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = ptr_inc(wr_ptr_reg);
    end
    if (pop) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    if (push && !pop) begin
      count_next = count_reg + CntW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CntW'(1);
    end
  end

  // Pointer and count registers; flush empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_slot
      logic valid_reg;
      logic mark_reg;

      // Per-slot occupancy and mark; a push into the slot being popped wins
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          mark_reg  <= 1'b0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (push && (wr_ptr_reg == PtrW'(gi))) begin
          valid_reg <= 1'b1;
          mark_reg  <= push_mark;
        end else if (pop && (rd_ptr_reg == PtrW'(gi))) begin
          valid_reg <= 1'b0;
        end
      end

      assign slot_live[gi] = valid_reg & mark_reg;
    end
  endgenerate

  assign pop_data = pop_data_reg;
  assign count    = count_reg;
  assign full     = (count_reg == CntW'(Depth));
  assign empty    = (count_reg == '0);
  assign any_mark = |slot_live;

endmodule

// File: rtl/dmi_jtag_ctrl.sv
// TCK-domain DMI transaction controller between the JTAG TAP DR strobes
// and the DMI CDC. Queues up to ReqDepth scans, issues them one at a time,
// tracks sticky busy/failed errors and handles dmireset/dmihardreset.
// Optional build macro DMI_JTAG_CTRL_ERR_CNT_EN adds busy_cnt_o, a
// saturating count of Busy events.
module dmi_jtag_ctrl
  import dmi_jtag_ctrl_pkg::*;
#(
  parameter int AbitsWidth = 7,
  parameter int ReqDepth   = 2,
  parameter int DataWidth  = 32
) (
  input  logic                              tck_i,
  input  logic                              trst_ni,
  input  logic                              test_logic_reset_i,
  input  logic                              capture_dr_i,
  input  logic                              shift_dr_i,
  input  logic                              update_dr_i,
  input  logic                              dmi_access_i,
  input  logic                              dtmcs_select_i,
  input  logic                              dmi_reset_i,
  input  logic                              dmi_hard_reset_i,
  input  logic                              dmi_tdi_i,
  output logic                              dmi_tdo_o,
  output logic [1:0]                        dmi_error_o,
  output logic [$clog2(ReqDepth+1):0]       pending_o,
`ifdef DMI_JTAG_CTRL_ERR_CNT_EN
  output logic [7:0]                        busy_cnt_o,
`endif
  dmi_jtag_ctrl_if.master                   dmi
);

  localparam int DrWidth = AbitsWidth + DmiReqBodyWidth;
  localparam int CntW    = $clog2(ReqDepth + 1);
  localparam int PendW   = CntW + 1;

  if (DataWidth != DmiDataWidth) begin : g_bad_data_width
    $error("dmi_jtag_ctrl: DataWidth must be 32");
  end
  if ((ReqDepth < 1) || ((ReqDepth & (ReqDepth - 1)) != 0)) begin : g_bad_depth
    $error("dmi_jtag_ctrl: ReqDepth must be a power of two >= 1");
  end

  logic [DrWidth-1:0]      dr_reg, dr_next;
  logic [1:0]              state_reg, state_next;
  logic [1:0]              error_reg, error_next;
  logic [AbitsWidth-1:0]   last_addr_reg;
  logic [DmiDataWidth-1:0] last_data_reg;
  logic                    discard_reg, discard_next;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_any_read;
  logic [DrWidth-1:0]      fifo_head;
  logic [CntW-1:0]         fifo_count;

  logic [1:0]              dr_op;
  logic                    dr_is_rw;
  logic                    soft_clr, hard_clr;
  logic                    upd_en, cap_en, shift_en;
  logic                    drop_busy, cap_busy, resp_busy, resp_failed;
  logic                    resp_done, resp_take;
  logic                    read_pending;
  logic [1:0]              cap_status;
  dmi_req_body_t           issued_body;
  logic [AbitsWidth-1:0]   issued_addr;

  assign dr_op       = dr_reg[1:0];
  assign dr_is_rw    = is_rw_op(dr_op);
  assign soft_clr    = dmi_reset_i & dtmcs_select_i;
  assign hard_clr    = dmi_hard_reset_i & dtmcs_select_i;
  assign upd_en      = update_dr_i & dmi_access_i & (error_reg == NoError) & ~hard_clr;
  assign cap_en      = capture_dr_i & dmi_access_i;
  assign shift_en    = shift_dr_i & dmi_access_i;

  assign issued_body = fifo_head[DmiReqBodyWidth-1:0];
  assign issued_addr = fifo_head[DrWidth-1:DmiReqBodyWidth];

  // A hard reset freezes the queue for a cycle so the flush sees a stable FIFO
  assign fifo_pop    = (state_reg == CtrlIdle) & ~fifo_empty & ~hard_clr;
  assign fifo_push   = upd_en & dr_is_rw & (~fifo_full | fifo_pop);
  assign drop_busy   = upd_en & dr_is_rw & fifo_full & ~fifo_pop;

  // Reads still owed to the host make a capture report busy
  assign read_pending = fifo_any_read |
                        ((state_reg != CtrlIdle) & (issued_body.op == DTM_READ));
  assign cap_busy     = cap_en & read_pending;
  assign cap_status   = read_pending ? Busy : error_reg;

  assign resp_done   = (state_reg == CtrlWait) & dmi.resp_valid;
  assign resp_take   = resp_done & ~discard_reg & ~hard_clr;
  assign resp_failed = resp_take & (dmi.resp_resp == Failed);
  assign resp_busy   = resp_take & (dmi.resp_resp == Busy);

  dmi_jtag_ctrl_req_fifo #(
    .Depth (ReqDepth),
    .Width (DrWidth)
  ) u_req_fifo (
    .clk       (tck_i),
    .rst_n     (trst_ni),
    .flush     (hard_clr),
    .push      (fifo_push),
    .push_data (dr_reg),
    .push_mark (dr_op == DTM_READ),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .any_mark  (fifo_any_read)
  );

  // DR shift register: TLR clear, then capture, then shift
  always_comb begin
    dr_next = dr_reg;
    if (test_logic_reset_i) begin
      dr_next = '0;
    end else if (cap_en) begin
      dr_next = {last_addr_reg, last_data_reg, cap_status};
    end else if (shift_en) begin
      dr_next = {dmi_tdi_i, dr_reg[DrWidth-1:1]};
    end
  end

  // Sticky error: dmireset/hardreset win, Failed outranks Busy
  always_comb begin
    error_next = error_reg;
    if (soft_clr || hard_clr) begin
      error_next = NoError;
    end else if (resp_failed) begin
      error_next = Failed;
    end else if ((drop_busy || cap_busy || resp_busy) && (error_reg != Failed)) begin
      error_next = Busy;
    end
  end

  // Transaction FSM: pop on Idle->Issue, handshake, then wait for response
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CtrlIdle:  if (fifo_pop)         state_next = CtrlIssue;
      CtrlIssue: if (dmi.req_ready)    state_next = CtrlWait;
      CtrlWait:  if (dmi.resp_valid)   state_next = CtrlIdle;
      default:                         state_next = CtrlIdle;
    endcase
  end

  // Response of a transaction in flight during a hard reset is dropped
  always_comb begin
    discard_next = discard_reg;
    if (resp_done) begin
      discard_next = 1'b0;
    end else if (hard_clr && (state_reg != CtrlIdle)) begin
      discard_next = 1'b1;
    end
  end

  // Controller state registers
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      dr_reg        <= '0;
      state_reg     <= CtrlIdle;
      error_reg     <= NoError;
      discard_reg   <= 1'b0;
      last_addr_reg <= '0;
      last_data_reg <= '0;
    end else begin
      dr_reg      <= dr_next;
      state_reg   <= state_next;
      error_reg   <= error_next;
      discard_reg <= discard_next;
      if (resp_take) begin
        last_addr_reg <= issued_addr;
        if (issued_body.op == DTM_READ) begin
          last_data_reg <= dmi.resp_data;
        end
      end
    end
  end

`ifdef DMI_JTAG_CTRL_ERR_CNT_EN
  logic [7:0] busy_cnt_reg;
  logic       busy_evt;

  assign busy_evt = drop_busy | cap_busy | resp_busy;

  // Saturating Busy event counter, cleared by hard reset
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      busy_cnt_reg <= '0;
    end else if (hard_clr) begin
      busy_cnt_reg <= '0;
    end else if (busy_evt && (busy_cnt_reg != 8'hFF)) begin
      busy_cnt_reg <= busy_cnt_reg + 8'd1;
    end
  end

  assign busy_cnt_o = busy_cnt_reg;
`endif

  assign dmi.req_valid  = (state_reg == CtrlIssue);
  assign dmi.req_addr   = issued_addr;
  assign dmi.req_data   = issued_body.data;
  assign dmi.req_op     = issued_body.op;
  assign dmi.resp_ready = 1'b1;

  assign dmi_tdo_o   = dr_reg[0];
  assign dmi_error_o = error_reg;
  assign pending_o   = PendW'(fifo_count) + PendW'(state_reg != CtrlIdle);

endmodule
